// File: rtl/enemy_control_if.sv
// enemy_control_if: player/tick inputs and datapath-facing outputs of the enemy sequencer
interface enemy_control_if;
    logic       tick;
    logic       start;
    logic       game_over;
    logic [1:0] player_x_pos;
    logic       player_block;
    logic       player_punch;
    logic [1:0] x_pos;
    logic       speed;
    logic       attack;
    logic       hit_player;
    logic       enemy_hit;
    logic [3:0] hit_count;
    logic [2:0] state_out;

    modport master (
        output tick, start, game_over, player_x_pos, player_block, player_punch,
        input  x_pos, speed, attack, hit_player, enemy_hit, hit_count, state_out
    );

    modport slave (
        input  tick, start, game_over, player_x_pos, player_block, player_punch,
        output x_pos, speed, attack, hit_player, enemy_hit, hit_count, state_out
    );
endinterface

// File: rtl/enemy_control.sv
// enemy_control: tick-paced enemy fight sequencer; define ENEMY_FEINT_EN to let WINDUP feint back to DWELL
module enemy_control #(
    parameter int         DWELL_TICKS   = 4,
    parameter int         WINDUP_TICKS  = 2,
    parameter int         ATTACK_TICKS  = 1,
    parameter int         RECOVER_TICKS = 3,
    parameter int         STUN_TICKS    = 4,
    parameter int         SPEEDUP_HITS  = 3,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input logic           clock,
    input logic           resetn,
    enemy_control_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE    = 3'd1,
        S_DWELL   = 3'd2,
        S_WINDUP  = 3'd3,
        S_ATTACK  = 3'd4,
        S_RECOVER = 3'd5,
        S_STUNNED = 3'd6
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_lfsr;
    logic [1:0] r_x_pos;
    logic       r_speed;
    logic       r_attack;
    logic       r_hit_player;
    logic       r_enemy_hit;
    logic [3:0] r_hit_count;

    logic [7:0] w_limit;
    logic       w_done;
    logic       w_punched;
    logic       w_feint;
    logic [1:0] w_lfsr_lane;
    logic [1:0] w_cand;

`ifdef ENEMY_FEINT_EN
    assign w_feint = r_lfsr[7];
`else
    assign w_feint = 1'b0;
`endif

    // last counter value of the current timed state
    always_comb begin
        case (r_state)
            S_DWELL:   w_limit = 8'(DWELL_TICKS - 1);
            S_WINDUP:  w_limit = 8'(WINDUP_TICKS - 1);
            S_ATTACK:  w_limit = 8'(ATTACK_TICKS - 1);
            S_RECOVER: w_limit = 8'(RECOVER_TICKS - 1);
            S_STUNNED: w_limit = 8'(STUN_TICKS - 1);
            default:   w_limit = 8'd0;
        endcase
    end

    assign w_done      = bus.tick && (r_cnt == w_limit);
    assign w_punched   = bus.player_punch && (bus.player_x_pos == r_x_pos) &&
                         (r_state == S_DWELL || r_state == S_RECOVER);
    assign w_lfsr_lane = (r_lfsr[1:0] == 2'b11) ? 2'b01 : r_lfsr[1:0];
    assign w_cand      = (w_lfsr_lane != r_x_pos) ? w_lfsr_lane :
                         (r_x_pos == 2'd2) ? 2'd0 : r_x_pos + 2'd1;

    // free-running lane randomiser, taps 8,6,5,4
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    // fight FSM with registered datapath outputs and hit resolution
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_x_pos      <= 2'b01;
            r_speed      <= 1'b0;
            r_attack     <= 1'b0;
            r_hit_player <= 1'b0;
            r_enemy_hit  <= 1'b0;
            r_hit_count  <= 4'd0;
        end else begin
            r_hit_player <= 1'b0;
            r_enemy_hit  <= 1'b0;
            r_speed      <= (r_hit_count >= 4'(SPEEDUP_HITS));
            if (bus.game_over) begin
                r_state  <= S_IDLE;
                r_attack <= 1'b0;
                r_cnt    <= 8'd0;
            end else if (w_punched) begin
                r_state     <= S_STUNNED;
                r_cnt       <= 8'd0;
                r_enemy_hit <= 1'b1;
                if (r_hit_count != 4'hF)
                    r_hit_count <= r_hit_count + 4'd1;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.start) r_state <= S_MOVE;
                    S_MOVE: begin
                        r_x_pos <= w_cand;
                        r_state <= S_DWELL;
                        r_cnt   <= 8'd0;
                    end
                    default: if (bus.tick) begin
                        if (!w_done) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else begin
                            r_cnt <= 8'd0;
                            case (r_state)
                                S_DWELL: r_state <= S_WINDUP;
                                S_WINDUP: begin
                                    r_state  <= w_feint ? S_DWELL : S_ATTACK;
                                    r_attack <= !w_feint;
                                end
                                S_ATTACK: begin
                                    r_state      <= S_RECOVER;
                                    r_attack     <= 1'b0;
                                    r_hit_player <= (bus.player_x_pos == r_x_pos) && !bus.player_block;
                                end
                                default: r_state <= S_MOVE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign bus.x_pos      = r_x_pos;
    assign bus.speed      = r_speed;
    assign bus.attack     = r_attack;
    assign bus.hit_player = r_hit_player;
    assign bus.enemy_hit  = r_enemy_hit;
    assign bus.hit_count  = r_hit_count;
    assign bus.state_out  = r_state;
endmodule

// File: doc/enemy_control.md
Name: enemy_control

Overview:
- Upstream sequencer for the enemy datapath. Drives its x_pos, speed and attack inputs.
- Runs a tick-paced fight FSM: move to a lane, dwell, wind up, attack, recover, and go stunned when the player lands a punch.
- Resolves player-hit and enemy-hit events, and counts hits taken so the enemy speeds up as the fight goes on.
- Tick comes from an external rate_divider: one-cycle pulse, count reaches zero.

Parameters:
- DWELL_TICKS, 4, ticks spent in DWELL before WINDUP.
- WINDUP_TICKS, 2, ticks spent in WINDUP before ATTACK.
- ATTACK_TICKS, 1, ticks spent in ATTACK.
- RECOVER_TICKS, 3, ticks spent in RECOVER before MOVE.
- STUN_TICKS, 4, ticks spent in STUNNED before MOVE.
- SPEEDUP_HITS, 3, hit_count value at or above which speed=1.
- LFSR_SEED, 8'hA5, LFSR value after reset; must be nonzero.

Ports:
- clock  in  1  system clock, all state on posedge
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle pace pulse
- start  in  1  leave IDLE
- game_over  in  1  synchronous force to IDLE
- player_x_pos  in  2  player lane: 00, 01 or 10
- player_block  in  1  level, player guarding
- player_punch  in  1  one-cycle punch pulse
- x_pos  out  2  enemy lane to datapath: 00, 01 or 10; never 11
- speed  out  1  to datapath; 1 = fast
- attack  out  1  to datapath; high throughout ATTACK
- hit_player  out  1  one-cycle pulse, player struck
- enemy_hit  out  1  one-cycle pulse, enemy struck
- hit_count  out  4  hits taken, saturates at 15
- state_out  out  3  current state encoding, for debug

Behaviour:
- Reset values (async): state=IDLE, x_pos=01, speed=0, attack=0, hit_player=0, enemy_hit=0, hit_count=0, lfsr=LFSR_SEED, tick counter=0. All outputs are registered.
- State encodings: IDLE=0, MOVE=1, DWELL=2, WINDUP=3, ATTACK=4, RECOVER=5, STUNNED=6.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clock regardless of state.
- Timed states (DWELL, WINDUP, ATTACK, RECOVER, STUNNED):
  - Tick counter clears on state entry and increments on each tick.
  - State exits at the clock edge where tick=1 and counter == N-1, so it lasts exactly N ticks.
  - tick has no effect in IDLE or MOVE.
- IDLE: holds outputs. start=1 -> MOVE on the next edge.
- MOVE: lasts one cycle.
  - candidate = lfsr[1:0], with 11 mapped to 01.
  - If candidate == current x_pos, candidate = (x_pos+1) mod 3.
  - x_pos <= candidate, then go to DWELL. The enemy always changes lane.
- DWELL -> WINDUP after DWELL_TICKS.
- WINDUP -> ATTACK after WINDUP_TICKS.
- ATTACK:
  - attack=1 for the whole state.
  - On the exit edge: if player_x_pos == x_pos and player_block == 0, pulse hit_player for one cycle.
  - Then go to RECOVER.
- RECOVER -> MOVE after RECOVER_TICKS.
- Punch resolution: player_punch with player_x_pos == x_pos while in DWELL or RECOVER:
  - Pulse enemy_hit.
  - hit_count++ (saturating).
  - Go to STUNNED, overriding any same-cycle tick exit.
- Punch in any other state is ignored.
- STUNNED -> MOVE after STUN_TICKS.
- speed is registered: 1 iff hit_count >= SPEEDUP_HITS. It updates the cycle after hit_count changes.
- game_over=1: next edge goes to IDLE with attack=0 and pulses=0. x_pos and hit_count hold.
- game_over has priority over all other transitions.
- Reset mid-state: immediate return to reset values, with no pulse emitted.

Optional Feature:
- Macro: ENEMY_FEINT_EN.
- Defined: on the WINDUP exit edge, if lfsr[7]==1, go to DWELL instead of ATTACK. The tick counter clears, attack stays 0 and no hit is resolved.
- Undefined: WINDUP always goes to ATTACK. lfsr[7] is unused.

Test Plan:
- Reset, start pulse, 4 ticks -> MOVE lasts 1 cycle, x_pos != 01, state 2 -> 3 on the 4th tick edge.
- Run to ATTACK with player_x_pos=x_pos and player_block=0 -> attack=1 for 1 tick, then a single-cycle hit_player, state=5.
- Same run with player_block=1 -> no hit_player, state=5.
- Punch in DWELL, matching lane, on the same cycle as the 4th tick -> enemy_hit pulse, hit_count=1, state=6 (not 3).
- Three successful punches -> hit_count=3, speed=1 one cycle later.
- Punch during WINDUP -> ignored.
- game_over during ATTACK -> next cycle state=0 and attack=0.
- Deassert then reassert resetn mid-DWELL -> all reset values.
- 200 MOVEs -> x_pos never 11 and never repeats.
